// File: rtl/crypto_seq_pkg.sv
// crypto_seq_pkg: shared state, mode, status and strobe encodings for the command sequencer
package crypto_seq_pkg;
  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_GET,
    RUN,
    WAIT_KEY,
    WAIT_FIN,
    RESP
  } state_e;
  localparam logic [1:0] MODE_ENC    = 2'b01;
  localparam logic [1:0] MODE_DEC    = 2'b10;
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MODE    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_SEQ     = 2'b11;
  // Strobe vector order: {get, cnt, out_data, out_key, fin}
  localparam logic [4:0] STB_GET  = 5'b10000;
  localparam logic [4:0] STB_CNT  = 5'b01000;
  localparam logic [4:0] STB_DATA = 5'b00100;
  localparam logic [4:0] STB_KEY  = 5'b00010;
  localparam logic [4:0] STB_FIN  = 5'b00001;
  function automatic logic mode_legal(input logic [1:0] m);
    return m == MODE_ENC || m == MODE_DEC;
  endfunction
endpackage

// File: rtl/crypto_cmd_sequencer_if.sv
// crypto_cmd_sequencer_if: host request/response channels of the command sequencer
interface crypto_cmd_sequencer_if;
  logic       req_valid;
  logic [1:0] req_mode;
  logic       req_ready;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_err;
  logic [2:0] rsp_rounds;
  modport master (
    output req_valid, req_mode, rsp_ready,
    input  req_ready, rsp_valid, rsp_err, rsp_rounds
  );
  modport slave (
    input  req_valid, req_mode, rsp_ready,
    output req_ready, rsp_valid, rsp_err, rsp_rounds
  );
endinterface

// File: rtl/crypto_watchdog.sv
// crypto_watchdog: counts idle enabled cycles; expired flags the TIMEOUT-th one
module crypto_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (!en || clr) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  // Independent of clr so the FSM can use it without a loop; strobes take priority there
  assign expired = en && cnt_q == W'(TIMEOUT - 1);
endmodule

// File: rtl/crypto_cmd_sequencer.sv
// crypto_cmd_sequencer: launches the crypto control unit per command, tracks its strobes,
// owns the round counter and reports a status response
module crypto_cmd_sequencer
  import crypto_seq_pkg::*;
#(
  parameter int ROUNDS  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  crypto_cmd_sequencer_if.slave        host,
  output logic                         bgn,
  output logic [1:0]                   cript_or_decript,
  output logic [2:0]                   fin_counter,
  input  logic                         ctl_get,
  input  logic                         ctl_cnt,
  input  logic                         ctl_out_data,
  input  logic                         ctl_out_key,
  input  logic                         ctl_fin,
  output logic                         busy
);
  localparam logic [2:0] RMAX = 3'(ROUNDS);
  state_e     state_q, state_d, step_to;
  logic [1:0] mode_q, mode_d, err_q, err_d;
  logic [2:0] fin_q, fin_d;
  logic       bgn_q, bgn_d, rsp_valid_q, rsp_valid_d, busy_q, busy_d;
  logic [4:0] stb;
  logic       any, legal, step_ok, wd_en, wd_clr, expired;
  assign stb    = {ctl_get, ctl_cnt, ctl_out_data, ctl_out_key, ctl_fin};
  assign any    = |stb;
  assign legal  = mode_legal(host.req_mode);
  assign wd_en  = state_q inside {WAIT_GET, RUN, WAIT_KEY, WAIT_FIN};
  assign wd_clr = any || state_d != state_q;
  crypto_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk    (clk),
    .rst    (rst),
    .en     (wd_en),
    .clr    (wd_clr),
    .expired(expired)
  );
  // Exact-match compares reject simultaneous strobes as well as out-of-order ones
  always_comb begin
    step_ok = 1'b0;
    step_to = state_q;
    case (state_q)
      WAIT_GET: begin
        step_ok = stb == STB_GET;
        step_to = RUN;
      end
      RUN: begin
        step_ok = (stb == STB_CNT && fin_q < RMAX) || (stb == STB_DATA && fin_q == RMAX);
        step_to = ctl_cnt ? RUN : WAIT_KEY;
      end
      WAIT_KEY: begin
        step_ok = stb == STB_KEY;
        step_to = WAIT_FIN;
      end
      WAIT_FIN: begin
        step_ok = stb == STB_FIN;
        step_to = RESP;
      end
      default: ;
    endcase
  end
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    err_d   = err_q;
    fin_d   = fin_q;
    if (state_q == IDLE && host.req_valid) begin
      mode_d  = legal ? host.req_mode : 2'b00;
      err_d   = legal ? ERR_OK : ERR_MODE;
      fin_d   = '0;
      state_d = legal ? LAUNCH : RESP;
    end else if (state_q == LAUNCH) begin
      state_d = WAIT_GET;
    end else if (state_q == RESP && host.rsp_ready) begin
      state_d = IDLE;
      mode_d  = 2'b00;
    end else if (wd_en && any) begin
      state_d = step_ok ? step_to : RESP;
      err_d   = step_ok ? err_q : ERR_SEQ;
      fin_d   = (step_ok && ctl_cnt) ? fin_q + 3'd1 : fin_q;
    end else if (wd_en && expired) begin
      state_d = RESP;
      err_d   = ERR_TIMEOUT;
    end
  end
  always_comb begin
    bgn_d       = state_d == LAUNCH;
    rsp_valid_d = state_d == RESP;
    busy_d      = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q     <= IDLE;
      mode_q      <= 2'b00;
      err_q       <= ERR_OK;
      fin_q       <= '0;
      bgn_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      fin_q       <= fin_d;
      bgn_q       <= bgn_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  assign host.req_ready  = state_q == IDLE;
  assign host.rsp_valid  = rsp_valid_q;
  assign host.rsp_err    = err_q;
  assign host.rsp_rounds = fin_q;
  assign bgn              = bgn_q;
  assign cript_or_decript = mode_q;
  assign fin_counter      = fin_q;
  assign busy             = busy_q;
endmodule

// File: tb/tb_crypto_cmd_sequencer.sv
// tb_crypto_cmd_sequencer: directed and randomized commands checked against a
// sequence-level model of the legal strobe order, watchdog and response rules
module tb_crypto_cmd_sequencer;
  import crypto_seq_pkg::*;
  localparam int ROUNDS  = 4;
  localparam int TIMEOUT = 8;
  localparam logic [4:0] GET = 5'h10, CNT = 5'h08, DAT = 5'h04, KEY = 5'h02, FIN = 5'h01;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] stb = '0;
  logic       bgn, busy;
  logic [1:0] cod;
  logic [2:0] fin_counter;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [4:0] ev[$];
  int         gp[$];
  int         c;
  logic [1:0] m;
  crypto_cmd_sequencer_if hif ();
  crypto_cmd_sequencer #(.ROUNDS(ROUNDS), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .rst             (rst),
    .host            (hif),
    .bgn             (bgn),
    .cript_or_decript(cod),
    .fin_counter     (fin_counter),
    .ctl_get         (stb[4]),
    .ctl_cnt         (stb[3]),
    .ctl_out_data    (stb[2]),
    .ctl_out_key     (stb[1]),
    .ctl_fin         (stb[0]),
    .busy            (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Expected outcome from the rule "events must follow get, cnt x ROUNDS, data, key, fin"
  function automatic void model(input logic [1:0] mode, output logic [1:0] e,
                                output logic [2:0] r, output int t);
    logic [4:0] seq[$];
    r = '0;
    t = -2;
    e = ERR_TIMEOUT;
    if (mode != MODE_ENC && mode != MODE_DEC) begin
      e = ERR_MODE;
      t = -3;
      return;
    end
    seq.push_back(GET);
    repeat (ROUNDS) seq.push_back(CNT);
    seq.push_back(DAT);
    seq.push_back(KEY);
    seq.push_back(FIN);
    foreach (ev[i]) begin
      if (gp[i] >= TIMEOUT) begin
        t = -1;
        return;
      end
      if (i >= seq.size() || ev[i] != seq[i]) begin
        e = ERR_SEQ;
        t = i;
        return;
      end
      if (ev[i] == CNT) r++;
      if (i == seq.size() - 1) begin
        e = ERR_OK;
        t = i;
        return;
      end
    end
  endfunction
  task automatic set_legal(input int maxgap);
    ev.delete();
    gp.delete();
    ev.push_back(GET);
    repeat (ROUNDS) ev.push_back(CNT);
    ev.push_back(DAT);
    ev.push_back(KEY);
    ev.push_back(FIN);
    foreach (ev[i]) gp.push_back($urandom_range(0, maxgap));
  endtask
  task automatic run_cmd(input logic [1:0] mode, input int bp);
    logic [1:0] xe;
    logic [2:0] xr;
    int t, n, bgn_n, rc;
    logic lg;
    lg = mode == MODE_ENC || mode == MODE_DEC;
    model(mode, xe, xr, t);
    rc = 0;
    hif.req_valid = 1'b1;
    hif.req_mode  = mode;
    tick();
    hif.req_valid = 1'b0;
    hif.req_mode  = 2'b00;
    bgn_n = int'(bgn);
    chk("busy_accept", busy, 1);
    chk("req_ready_busy", hif.req_ready, 0);
    if (lg) begin
      chk("mode_launch", cod, mode);
      tick();
      bgn_n += int'(bgn);
      foreach (ev[i]) begin
        repeat (gp[i]) begin
          tick();
          bgn_n += int'(bgn);
        end
        stb = ev[i];
        tick();
        stb = '0;
        bgn_n += int'(bgn);
        if (t >= 0 && i < t && ev[i] == CNT) rc++;
        if (t >= 0 && i <= t) chk("fin_step", fin_counter, rc);
        if (i == t) chk("rsp_latency", hif.rsp_valid, 1);
        chk("mode_hold", cod, mode);
      end
    end
    n = 0;
    while (!hif.rsp_valid && n < 4 * TIMEOUT) begin
      tick();
      n++;
      bgn_n += int'(bgn);
    end
    chk("rsp_valid", hif.rsp_valid, 1);
    if (t == -2) chk("wd_latency", n, TIMEOUT);
    chk("bgn_pulses", bgn_n, lg);
    for (int k = 0; k <= bp; k++) begin
      chk("rsp_held", hif.rsp_valid, 1);
      chk("rsp_err", hif.rsp_err, xe);
      chk("rsp_rounds", hif.rsp_rounds, xr);
      chk("mode_resp", cod, lg ? mode : 2'b00);
      if (k < bp) tick();
    end
    hif.rsp_ready = 1'b1;
    tick();
    hif.rsp_ready = 1'b0;
    chk("rsp_done", hif.rsp_valid, 0);
    chk("req_ready_idle", hif.req_ready, 1);
    chk("busy_idle", busy, 0);
    chk("mode_idle", cod, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    hif.req_valid = 1'b0;
    hif.req_mode  = 2'b00;
    hif.rsp_ready = 1'b0;
    #2;
    chk("rst_bgn", bgn, 0);
    chk("rst_mode", cod, 0);
    chk("rst_fin", fin_counter, 0);
    chk("rst_rsp_valid", hif.rsp_valid, 0);
    chk("rst_rsp_err", hif.rsp_err, 0);
    chk("rst_rsp_rounds", hif.rsp_rounds, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    chk("rst_req_ready", hif.req_ready, 1);
    set_legal(1);
    run_cmd(MODE_ENC, 0);
    set_legal(1);
    run_cmd(MODE_DEC, 5);
    ev.delete();
    gp.delete();
    run_cmd(2'b00, 0);
    run_cmd(2'b11, 1);
    ev = {GET};
    gp = {2};
    run_cmd(MODE_ENC, 0);
    ev = {GET, CNT, CNT, CNT, CNT, CNT};
    gp = {0, 0, 1, 0, 0, 1};
    run_cmd(MODE_ENC, 0);
    ev = {GET, CNT, KEY};
    gp = {1, 0, 0};
    run_cmd(MODE_DEC, 0);
    ev = {GET, CNT | DAT};
    gp = {0, 0};
    run_cmd(MODE_ENC, 0);
    hif.req_valid = 1'b1;
    hif.req_mode  = MODE_ENC;
    tick();
    hif.req_valid = 1'b0;
    tick();
    stb = GET;
    tick();
    stb = CNT;
    tick();
    stb = '0;
    tick();
    stb = CNT;
    tick();
    stb = '0;
    chk("fin_before_rst", fin_counter, 2);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_bgn", bgn, 0);
    chk("mid_rst_mode", cod, 0);
    chk("mid_rst_fin", fin_counter, 0);
    chk("mid_rst_rsp_valid", hif.rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    chk("post_rst_req_ready", hif.req_ready, 1);
    set_legal(1);
    run_cmd(MODE_ENC, 1);
    for (int k = 0; k < 30; k++) begin
      m = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3))
                                      : ($urandom_range(0, 1) != 0 ? MODE_ENC : MODE_DEC);
      set_legal(2);
      if ($urandom_range(0, 2) == 0) ev[$urandom_range(0, ev.size() - 1)] = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 3) == 0) begin
        c = $urandom_range(0, ev.size());
        while (ev.size() > c) begin
          void'(ev.pop_back());
          void'(gp.pop_back());
        end
      end
      if (gp.size() > 0 && $urandom_range(0, 5) == 0)
        gp[$urandom_range(0, gp.size() - 1)] = TIMEOUT - $urandom_range(0, 1);
      if (m != MODE_ENC && m != MODE_DEC) begin
        ev.delete();
        gp.delete();
      end
      run_cmd(m, $urandom_range(0, 3));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
